// File: rtl/ship_placement_ctrl.sv
// Ship-placement sequencer: synchronizes the place button, validates the cursor cell,
// writes accepted cells to the board and counts the fleet until it is complete.
module ship_placement_ctrl #(
  parameter int GRID_SIZE     = 5,
  parameter int NUM_SHIPS     = 5,
  parameter int REJECT_CYCLES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   place_n,
  input  logic [2:0]                             cursor_i,
  input  logic [2:0]                             cursor_j,
  output logic                                   colocation_ships_State,
  output logic                                   board_clear,
  output logic                                   cell_we,
  output logic [$clog2(GRID_SIZE*GRID_SIZE)-1:0] cell_addr,
  output logic [GRID_SIZE*GRID_SIZE-1:0]         occupied,
  output logic [$clog2(NUM_SHIPS+1)-1:0]         ships_placed,
  output logic                                   reject,
  output logic                                   placement_done
);

  localparam int NCELL = GRID_SIZE * GRID_SIZE;
  localparam int AW    = $clog2(NCELL);
  localparam int SW    = $clog2(NUM_SHIPS + 1);
  localparam int RW    = $clog2(REJECT_CYCLES + 1);
  localparam logic [3:0]    GRID_L = 4'(GRID_SIZE);
  localparam logic [SW-1:0] SHIPS_L = SW'(NUM_SHIPS);
  localparam logic [RW-1:0] REJ_L   = RW'(REJECT_CYCLES);

  typedef enum logic [2:0] {IDLE, PLACE, CHECK, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [2:0]        ci_q, ci_d, cj_q, cj_d;
  logic [AW-1:0]     cell_addr_q, cell_addr_d;
  logic              cell_we_q, cell_we_d;
  logic              board_clear_q, board_clear_d;
  logic              coloc_q, coloc_d;
  logic              done_q, done_d;
  logic [NCELL-1:0]  occupied_q, occupied_d;
  logic [SW-1:0]     ships_q, ships_d;
  logic [RW-1:0]     rej_cnt_q, rej_cnt_d;

  logic              press;
  logic [6:0]        addr_full;
  logic              cell_bad;
  logic [SW-1:0]     ships_inc;

  assign press     = s3_q & ~s2_q;
  assign addr_full = 7'(ci_q) * 7'(GRID_SIZE) + 7'(cj_q);
  // Out-of-range addresses shift the one-hot off the top, so the occupancy probe reads 0.
  assign cell_bad  = ({1'b0, ci_q} >= GRID_L) || ({1'b0, cj_q} >= GRID_L) ||
                     (|(occupied_q & (NCELL'(1) << addr_full)));
  assign ships_inc = ships_q + SW'(1);

  always_comb begin
    state_d       = state_q;
    ci_d          = ci_q;
    cj_d          = cj_q;
    cell_addr_d   = cell_addr_q;
    cell_we_d     = 1'b0;
    board_clear_d = 1'b0;
    occupied_d    = occupied_q;
    ships_d       = ships_q;
    rej_cnt_d     = (rej_cnt_q != '0) ? rej_cnt_q - RW'(1) : rej_cnt_q;

    unique case (state_q)
      IDLE, DONE, PLACE: begin
        if (start) begin
          state_d       = PLACE;
          board_clear_d = 1'b1;
          occupied_d    = '0;
          ships_d       = '0;
          rej_cnt_d     = '0;
        end else if (state_q == PLACE && press) begin
          state_d = CHECK;
          ci_d    = cursor_i;
          cj_d    = cursor_j;
        end
      end
      CHECK: begin
        if (cell_bad) begin
          state_d   = PLACE;
          rej_cnt_d = REJ_L;
        end else begin
          state_d     = WRITE;
          cell_addr_d = AW'(addr_full);
          cell_we_d   = 1'b1;
        end
      end
      WRITE: begin
        occupied_d = occupied_q | (NCELL'(1) << cell_addr_q);
        ships_d    = ships_inc;
        state_d    = (ships_inc == SHIPS_L) ? DONE : PLACE;
      end
      default: state_d = IDLE;
    endcase

    // Window stays open through CHECK/WRITE so the cursor never drops mid-placement.
    coloc_d = (state_d == PLACE) || (state_d == CHECK) || (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      s3_q          <= 1'b1;
      ci_q          <= '0;
      cj_q          <= '0;
      cell_addr_q   <= '0;
      cell_we_q     <= 1'b0;
      board_clear_q <= 1'b0;
      coloc_q       <= 1'b0;
      done_q        <= 1'b0;
      occupied_q    <= '0;
      ships_q       <= '0;
      rej_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= place_n;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      ci_q          <= ci_d;
      cj_q          <= cj_d;
      cell_addr_q   <= cell_addr_d;
      cell_we_q     <= cell_we_d;
      board_clear_q <= board_clear_d;
      coloc_q       <= coloc_d;
      done_q        <= done_d;
      occupied_q    <= occupied_d;
      ships_q       <= ships_d;
      rej_cnt_q     <= rej_cnt_d;
    end
  end

  assign colocation_ships_State = coloc_q;
  assign board_clear            = board_clear_q;
  assign cell_we                = cell_we_q;
  assign cell_addr              = cell_addr_q;
  assign occupied               = occupied_q;
  assign ships_placed           = ships_q;
  assign reject                 = rej_cnt_q != '0;
  assign placement_done         = done_q;

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Scoreboarded bench for ship_placement_ctrl: expected writes and reject pulse lengths are
// queued by the stimulus and consumed by a negedge monitor.
module tb_ship_placement_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, place_n;
  logic [2:0]  cursor_i, cursor_j;
  logic        colocation_ships_State, board_clear, cell_we, reject, placement_done;
  logic [4:0]  cell_addr;
  logic [24:0] occupied;
  logic [2:0]  ships_placed;

  int n_pass  = 0;
  int n_total = 0;
  int exp_addr_q[$];
  int exp_rej_q[$];
  int rej_run = 0;

  always #5 clk = ~clk;

  ship_placement_ctrl #(.GRID_SIZE(5), .NUM_SHIPS(5), .REJECT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .place_n(place_n),
    .cursor_i(cursor_i), .cursor_j(cursor_j),
    .colocation_ships_State(colocation_ships_State), .board_clear(board_clear),
    .cell_we(cell_we), .cell_addr(cell_addr), .occupied(occupied),
    .ships_placed(ships_placed), .reject(reject), .placement_done(placement_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every write strobe and every completed reject pulse must match a queued expectation.
  always @(negedge clk) begin
    if (cell_we === 1'b1) begin
      n_total++;
      if (exp_addr_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d expected no write at %0t", cell_addr, $time);
      end else begin
        int e;
        e = exp_addr_q.pop_front();
        if (int'(cell_addr) == e) n_pass++;
        else $display("FAIL write_addr: got %0d expected %0d at %0t", cell_addr, e, $time);
      end
    end
    if (reject === 1'b1) begin
      rej_run++;
    end else if (rej_run > 0) begin
      n_total++;
      if (exp_rej_q.size() == 0) begin
        $display("FAIL unexpected_reject: got %0d-cycle pulse expected none at %0t", rej_run, $time);
      end else begin
        int e;
        e = exp_rej_q.pop_front();
        if (rej_run == e) n_pass++;
        else $display("FAIL reject_len: got %0d expected %0d at %0t", rej_run, e, $time);
      end
      rej_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("board_clear_hi", board_clear, 1);
    check("window_open", colocation_ships_State, 1);
    check("ships_cleared", ships_placed, 0);
    check("occupied_cleared", occupied, 0);
    check("done_cleared", placement_done, 0);
    tick(1);
    check("board_clear_lo", board_clear, 0);
  endtask

  // Press at (i,j): button low for 3 cycles, then idle long enough for CHECK/WRITE/reject to finish.
  task automatic press(input logic [2:0] i, input logic [2:0] j, input bit lat_chk);
    cursor_i = i;
    cursor_j = j;
    place_n  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (k == 3) place_n = 1'b1;
      if (lat_chk) check($sformatf("latency_n%0d", k), cell_we, (k == 4) ? 1 : 0);
    end
    tick(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; place_n = 1'b0; cursor_i = 3'd0; cursor_j = 3'd0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("rst_outputs", {colocation_ships_State, board_clear, cell_we, reject, placement_done}, 0);
      check("rst_state", {ships_placed, occupied}, 0);
    end
    rst = 1'b0; start = 1'b0; place_n = 1'b1;
    tick(4);
    check("idle_window", colocation_ships_State, 0);

    // Normal fleet
    do_start();
    exp_addr_q.push_back(0);
    press(3'd0, 3'd0, 1'b1);
    check("ships_1", ships_placed, 1);
    exp_addr_q.push_back(7);
    press(3'd1, 3'd2, 1'b0);
    check("ships_2", ships_placed, 2);
    exp_addr_q.push_back(24);
    press(3'd4, 3'd4, 1'b0);
    check("ships_3", ships_placed, 3);
    exp_addr_q.push_back(13);
    press(3'd2, 3'd3, 1'b0);
    check("ships_4", ships_placed, 4);
    exp_addr_q.push_back(15);
    press(3'd3, 3'd0, 1'b0);
    check("ships_5", ships_placed, 5);
    check("done_hi", placement_done, 1);
    check("window_closed", colocation_ships_State, 0);
    check("fleet_bitmap", occupied, 32'h0100_A081);

    // Press while DONE must be ignored
    press(3'd1, 3'd1, 1'b0);
    check("done_hold_ships", ships_placed, 5);

    // Restart from DONE, then restart from PLACE
    do_start();
    exp_addr_q.push_back(24);
    press(3'd4, 3'd4, 1'b0);
    check("restart_ships", ships_placed, 1);
    check("restart_bitmap", occupied, 32'h0100_0000);
    do_start();

    // Duplicate cell
    exp_addr_q.push_back(12);
    press(3'd2, 3'd2, 1'b0);
    exp_rej_q.push_back(4);
    press(3'd2, 3'd2, 1'b0);
    check("dup_ships", ships_placed, 1);
    check("dup_window", colocation_ships_State, 1);

    // Out of range row, then column
    exp_rej_q.push_back(4);
    press(3'd5, 3'd0, 1'b0);
    check("oor_i_ships", ships_placed, 1);
    check("oor_i_window", colocation_ships_State, 1);
    exp_rej_q.push_back(4);
    press(3'd0, 3'd6, 1'b0);
    check("oor_j_ships", ships_placed, 1);

    // Held button: one write only
    cursor_i = 3'd1; cursor_j = 3'd1;
    exp_addr_q.push_back(6);
    place_n = 1'b0;
    tick(50);
    place_n = 1'b1;
    tick(5);
    check("held_ships", ships_placed, 2);

    // Toggling button: first press writes (3,3); the press that survives CHECK/WRITE re-hits it
    cursor_i = 3'd3; cursor_j = 3'd3;
    exp_addr_q.push_back(18);
    exp_rej_q.push_back(4);
    for (int k = 0; k < 6; k++) begin
      place_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    place_n = 1'b1;
    tick(12);
    check("toggle_ships", ships_placed, 3);
    check("toggle_bitmap", occupied, 32'h0004_1040);

    // Reset mid-placement: CHECK is aborted, no strobe follows
    cursor_i = 3'd0; cursor_j = 3'd1;
    place_n = 1'b0;
    tick(3);
    rst = 1'b1; place_n = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_outputs", {colocation_ships_State, cell_we, reject, placement_done}, 0);
    check("abort_state", {ships_placed, occupied}, 0);
    tick(6);

    check("writes_drained", exp_addr_q.size(), 0);
    check("rejects_drained", exp_rej_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ship_placement_ctrl.md
# ship_placement_ctrl

Sequencer for the ship-placement phase of the 5x5 battleship game. It opens and closes the placement window that enables the cursor controller, accepts active-low "place" button presses and validates the cell under the cursor (in range, not already occupied). It writes accepted cells to the board memory and counts ships until the configured fleet is placed. It sits between the button inputs, the cursor controller (which consumes `colocation_ships_State`) and the board/VGA drawing logic.

## Interface
Parameters:
- GRID_SIZE, 5: cells per row/column; legal values 2..8.
- NUM_SHIPS, 5: single-cell ships to place; legal values 1..GRID_SIZE*GRID_SIZE.
- REJECT_CYCLES, 4: length in cycles of the `reject` pulse; at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  synchronous pulse that begins or restarts placement.
- place_n  in  1  asynchronous active-low place button.
- cursor_i  in  3  cursor row from cursor controller.
- cursor_j  in  3  cursor column from cursor controller.
- colocation_ships_State  out  1  high while the placement window is open.
- board_clear  out  1  one-cycle pulse: external board memory must clear.
- cell_we  out  1  one-cycle board write strobe (data written is implicitly 1).
- cell_addr  out  $clog2(GRID_SIZE*GRID_SIZE)  write address = i*GRID_SIZE + j.
- occupied  out  GRID_SIZE*GRID_SIZE  bitmap of placed cells; bit index = address.
- ships_placed  out  $clog2(NUM_SHIPS+1)  accepted ships so far.
- reject  out  1  high for REJECT_CYCLES cycles after a refused press.
- placement_done  out  1  level, high once the fleet is complete.

## Operation
- States: IDLE, PLACE, CHECK, WRITE, DONE.
- place_n passes through a 2-flop synchronizer (s1, s2), plus a history flop s3. Internal `press` = s3 & ~s2, a single pulse per falling edge. A held button produces one press.
- IDLE: all outputs low. `start` -> PLACE. Also pulse board_clear, and clear occupied and ships_placed.
- PLACE: colocation_ships_State=1.
  - `press` -> CHECK. Latch cursor_i/cursor_j at the same edge.
  - `start` -> stays in PLACE; re-clears occupied and ships_placed; pulses board_clear.
- CHECK (one cycle): compute addr from latched i/j.
  - If i >= GRID_SIZE, j >= GRID_SIZE, or occupied[addr]=1: go to PLACE and load the reject counter with REJECT_CYCLES.
  - Otherwise: go to WRITE and register cell_addr=addr.
- WRITE (one cycle): cell_we=1 with cell_addr stable. At the exit edge, set occupied[addr] and increment ships_placed. If the new count == NUM_SHIPS go to DONE, else go to PLACE.
- DONE: colocation_ships_State=0 and placement_done=1. occupied and ships_placed are held. `start` -> PLACE with a full clear, as from IDLE.
- Ignored inputs:
  - `press` in CHECK, WRITE, IDLE or DONE; presses are not queued.
  - `start` in CHECK or WRITE. The in-flight placement completes, and a start on the following PLACE cycle is honoured.
- reject:
  - Counter-driven; counts down independently of state.
  - A new reject while it is counting reloads it to REJECT_CYCLES.
  - `start` or rst clears it.

## Timing
- Reset (rst high at an edge): state IDLE. All outputs 0. occupied=0, ships_placed=0, reject counter=0, synchronizer flops=1 (released).
- rst mid-placement aborts immediately; no write strobe follows.
- Button latency: place_n falls before edge E0. `press` is high during the cycle after E1, state is CHECK after E2, and cell_we is high in the cycle after E3. Worst case is 4 edges from pin to strobe.
- Rejected press: reject rises at the edge that leaves CHECK and stays high for exactly REJECT_CYCLES cycles.
- board_clear is high for exactly the cycle following the edge that accepts `start`.
- colocation_ships_State falls at the same edge that raises placement_done.
- ships_placed saturates at NUM_SHIPS by construction; no wrap.

## Test plan
- Reset: hold rst 3 cycles with place_n=0 and start=1. All outputs stay 0, and after release there is no spurious press.
- Normal fleet (defaults): start, then presses at (0,0),(1,2),(4,4),(2,3),(3,0). cell_addr sequence is 0,7,24,13,15, with one cell_we each. ships_placed goes 1..5. placement_done=1 and colocation_ships_State=0 after the fifth write.
- Duplicate cell: place (2,2), then press again at (2,2). Only one cell_we occurs (addr 12), reject is high exactly 4 cycles, and ships_placed stays 1.
- Out of range: press with cursor_i=5, cursor_j=0. No cell_we, reject is asserted, state returns to PLACE.
- Held/bouncing button: place_n held low 50 cycles gives exactly one write. place_n toggling every cycle for 6 cycles gives at most one press per synchronized falling edge, none of them during CHECK/WRITE.
- Restart: after DONE, pulse start. board_clear is a one-cycle pulse, occupied=0, ships_placed=0, colocation_ships_State=1, and placing (4,4) writes addr 24.
